// File: rtl/rsa_pkg.sv
// Shared RSA definitions: operand width and the start/done stage state encoding.
package rsa_pkg;
    localparam int RSA_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        UPDATE,
        END
    } rsa_state_e;
endpackage

// File: rtl/mod_mul.sv
// Bit-serial interleaved modular multiplier p = a*m mod n, MSB-first over m.
// One iteration per cycle for WIDTH cycles, then a one-cycle done pulse.
module mod_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);
    localparam logic [6:0] ITERS = 7'(WIDTH);

    logic [WIDTH+1:0] p_q, p_d, dbl, sub1;
    logic [WIDTH-1:0] a_q, m_q, n_q;
    logic [6:0]       cnt_q;
    logic             done_q;

    // 2p + a < 3n, so two conditional subtractions always bring p back below n.
    always_comb begin
        dbl  = (p_q << 1) + (m_q[WIDTH-1] ? {2'b00, a_q} : '0);
        sub1 = (dbl >= {2'b00, n_q}) ? dbl - {2'b00, n_q} : dbl;
        p_d  = (sub1 >= {2'b00, n_q}) ? sub1 - {2'b00, n_q} : sub1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q    <= '0;
            a_q    <= '0;
            m_q    <= '0;
            n_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                a_q   <= a;
                m_q   <= m;
                n_q   <= n;
                p_q   <= '0;
                cnt_q <= ITERS;
            end else if (cnt_q != '0) begin
                p_q   <= p_d;
                m_q   <= m_q << 1;
                cnt_q <= cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign p    = p_q[WIDTH-1:0];
    assign done = done_q;
endmodule

// File: rtl/mod_exp.sv
// Modular exponentiation base^e mod n, right-to-left square-and-multiply.
// Optional LOAD-time input range check enabled by defining MOD_EXP_INPUT_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start_compute; done/err cleared
// LOAD   | capture n, base, e; launch first multiply pair
// MUL    | wait for both mod_mul done pulses
// UPDATE | commit products, shift exponent, relaunch or finish
// END    | result/done_compute valid until start_compute drops
module mod_exp
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_compute,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             done_compute,
    output logic             err
);
    rsa_state_e       state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d, b_q, b_d, x_q, x_d, acc_q, acc_d, result_q, result_d;
    logic             done_q, done_d, err_q, err_d;
    logic             seen_mul_q, seen_mul_d, seen_sqr_q, seen_sqr_d;
    logic             launch, input_bad;
    logic [WIDTH-1:0] mul_p, sqr_p;
    logic             mul_done, sqr_done;

`ifdef MOD_EXP_INPUT_CHECK_EN
    assign input_bad = (n == '0) || (base >= n);
`else
    assign input_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        b_d        = b_q;
        x_d        = x_q;
        acc_d      = acc_q;
        result_d   = result_q;
        done_d     = done_q;
        err_d      = err_q;
        seen_mul_d = seen_mul_q;
        seen_sqr_d = seen_sqr_q;
        launch     = 1'b0;
        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                err_d  = 1'b0;
                if (start_compute) state_d = LOAD;
            end
            LOAD: begin
                n_d   = n;
                b_d   = base;
                x_d   = e;
                acc_d = (n == WIDTH'(1)) ? '0 : WIDTH'(1);
                if (input_bad) begin
                    acc_d   = '0;
                    err_d   = 1'b1;
                    state_d = END;
                end else if (e == '0) begin
                    state_d = END;
                end else begin
                    state_d = MUL;
                    launch  = 1'b1;
                end
            end
            MUL: begin
                seen_mul_d = seen_mul_q | mul_done;
                seen_sqr_d = seen_sqr_q | sqr_done;
                if (seen_mul_d && seen_sqr_d) begin
                    seen_mul_d = 1'b0;
                    seen_sqr_d = 1'b0;
                    state_d    = UPDATE;
                end
            end
            UPDATE: begin
                if (x_q[0]) acc_d = mul_p;
                b_d = sqr_p;
                x_d = x_q >> 1;
                if (x_d == '0) begin
                    state_d = END;
                end else begin
                    state_d = MUL;
                    launch  = 1'b1;
                end
            end
            END: begin
                result_d = acc_q;
                done_d   = 1'b1;
                // Only release once done_compute has actually been presented.
                if (!start_compute && done_q) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            b_q        <= '0;
            x_q        <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            seen_mul_q <= 1'b0;
            seen_sqr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            b_q        <= b_d;
            x_q        <= x_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            done_q     <= done_d;
            err_q      <= err_d;
            seen_mul_q <= seen_mul_d;
            seen_sqr_q <= seen_sqr_d;
        end
    end

    // Multipliers capture the next-state operands on the launch edge.
    mod_mul #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .reset(reset), .start(launch),
        .a(acc_d), .m(b_d), .n(n_d), .p(mul_p), .done(mul_done)
    );

    mod_mul #(.WIDTH(WIDTH)) u_sqr (
        .clk(clk), .reset(reset), .start(launch),
        .a(b_d), .m(b_d), .n(n_d), .p(sqr_p), .done(sqr_done)
    );

    assign result       = result_q;
    assign done_compute = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_mod_exp.sv
// Self-checking bench for mod_exp: directed vector table, corner sequences,
// and random operands checked against a plain-arithmetic reference model.
module tb_mod_exp;
    logic        clk = 1'b0;
    logic        reset, start_compute;
    logic [63:0] base, e, n, result;
    logic        done_compute, err;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mod_exp dut (
        .clk(clk), .reset(reset), .start_compute(start_compute),
        .base(base), .e(e), .n(n),
        .result(result), .done_compute(done_compute), .err(err)
    );

    typedef struct {
        logic [63:0] b;
        logic [63:0] ee;
        logic [63:0] nn;
        logic [63:0] res;
    } vec_t;

    function automatic logic [63:0] ref_modexp(input logic [63:0] b, input logic [63:0] ee,
                                               input logic [63:0] nn);
        logic [127:0] r, bb, m;
        m  = {64'd0, nn};
        r  = 128'd1 % m;
        bb = {64'd0, b} % m;
        for (int i = 0; i < 64; i++) begin
            if (ee[i]) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return r[63:0];
    endfunction

    function automatic int ref_latency(input logic [63:0] ee);
        int len = 0;
        for (int i = 0; i < 64; i++) if (ee[i]) len = i + 1;
        return 2 + 66 * len;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    // Start a run; cyc counts edges after the one sampling start_compute in IDLE.
    task automatic run(input logic [63:0] b, input logic [63:0] ee, input logic [63:0] nn,
                       output logic [63:0] res, output logic er, output int cyc);
        @(negedge clk);
        base = b; e = ee; n = nn; start_compute = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!done_compute && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                base = {$urandom, $urandom};
                e    = {$urandom, $urandom};
                n    = {$urandom, $urandom};
            end
        end
        res = result;
        er  = err;
    endtask

    task automatic release_start(input string name);
        @(negedge clk);
        start_compute = 1'b0;
        @(posedge clk); #1;
        chk({name, "_done_clr"}, 64'(done_compute), 64'd0);
    endtask

    task automatic do_vec(input string name, input logic [63:0] b, input logic [63:0] ee,
                          input logic [63:0] nn, input logic [63:0] exp_res);
        logic [63:0] res;
        logic        er;
        int          cyc;
        run(b, ee, nn, res, er, cyc);
        chk({name, "_result"}, res, exp_res);
        chk({name, "_err"}, 64'(er), 64'd0);
        chk({name, "_latency"}, 64'(cyc), 64'(ref_latency(ee)));
        release_start(name);
    endtask

    vec_t vecs[6];

    initial begin
        logic [63:0] res, rb, re, rn;
        logic        er;
        int          cyc;

        vecs[0] = '{64'd4, 64'd13, 64'd497, 64'd445};
        vecs[1] = '{64'd65, 64'd17, 64'd3233, 64'd2790};
        vecs[2] = '{64'd2790, 64'd2753, 64'd3233, 64'd65};
        vecs[3] = '{64'd5, 64'd0, 64'd7, 64'd1};
        vecs[4] = '{64'd0, 64'd9, 64'd1, 64'd0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFC4, 64'd2, 64'hFFFF_FFFF_FFFF_FFC5, 64'd1};

        reset = 1'b1; start_compute = 1'b0;
        base = '0; e = '0; n = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 64'd0);
        chk("rst_done", 64'(done_compute), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_vec($sformatf("vec%0d", i), vecs[i].b, vecs[i].ee, vecs[i].nn, vecs[i].res);
        end

        // Holding start high in END keeps the result presented.
        run(64'd4, 64'd13, 64'd497, res, er, cyc);
        chk("hold_latency", 64'(cyc), 64'd266);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_done", 64'(done_compute), 64'd1);
        chk("hold_result", result, 64'd445);
        release_start("hold");

        // base >= n: range check or plain completion depending on build.
        run(64'd10, 64'd3, 64'd10, res, er, cyc);
`ifdef MOD_EXP_INPUT_CHECK_EN
        chk("chk_err", 64'(er), 64'd1);
        chk("chk_result", res, 64'd0);
        chk("chk_latency", 64'(cyc), 64'd2);
`else
        chk("chk_err", 64'(er), 64'd0);
        chk("chk_latency", 64'(cyc), 64'(ref_latency(64'd3)));
`endif
        release_start("chk");

        for (int i = 0; i < 10; i++) begin
            rn = {$urandom, $urandom};
            if (rn < 64'd2) rn = 64'd2;
            rb = {$urandom, $urandom} % rn;
            re = (i < 8) ? 64'($urandom_range(0, 65535)) : {$urandom, $urandom};
            do_vec($sformatf("rnd%0d", i), rb, re, rn, ref_modexp(rb, re, rn));
        end

        // Reset during the 30th MUL cycle of a run; result holds a nonzero value beforehand.
        @(negedge clk);
        base = 64'd4; e = 64'd13; n = 64'd497; start_compute = 1'b1;
        @(posedge clk);
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_result", result, 64'd0);
        chk("mid_rst_done", 64'(done_compute), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        reset = 1'b0;
        start_compute = 1'b0;
        @(posedge clk); #1;
        do_vec("after_rst", 64'd4, 64'd13, 64'd497, 64'd445);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
